// File: rtl/decoder_scan_ctrl.sv
// Channel scanner driving sel/en of a 3-to-8 decoder: programmable scan order and dwell,
// one blanked cycle between channels (break-before-make), and a pulse at the end of each sweep.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [DWELL_W-1:0] w_dwell_eff;
  logic [1:0]         r_mode, w_mode_nxt;
  logic               r_down, w_down_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic               r_en, r_busy, r_sweep_done;
  logic               w_sd_nxt;
  logic [2:0]         w_step_sel;
  logic               w_step_down;
  logic               w_step_sd;
  logic               w_last;

  assign sel        = r_sel;
  assign en         = r_en;
  assign busy       = r_busy;
  assign sweep_done = r_sweep_done;

  assign w_dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
  assign w_last      = (r_cnt == DWELL_ONE);

  // Next channel, direction and end-of-sweep flag for the channel being left.
  always_comb begin
    w_step_sel  = r_sel + 3'd1;
    w_step_down = r_down;
    w_step_sd   = 1'b0;
    case (r_mode)
      2'b00: begin
        w_step_sel = r_sel + 3'd1;
        w_step_sd  = (r_sel == 3'd7);
      end
      2'b01: begin
        w_step_sel = r_sel - 3'd1;
        w_step_sd  = (r_sel == 3'd0);
      end
      2'b10: begin
        w_step_sel = r_sel + 3'd1;
        w_step_sd  = (r_sel == 3'd7);
      end
      2'b11: begin
        if (!r_down) begin
          if (r_sel == 3'd7) begin
            w_step_sel  = 3'd6;
            w_step_down = 1'b1;
            w_step_sd   = 1'b1;
          end else begin
            w_step_sel = r_sel + 3'd1;
          end
        end else begin
          if (r_sel == 3'd0) begin
            w_step_sel  = 3'd1;
            w_step_down = 1'b0;
            w_step_sd   = 1'b1;
          end else begin
            w_step_sel = r_sel - 3'd1;
          end
        end
      end
      default: begin
        w_step_sel = r_sel + 3'd1;
      end
    endcase
  end

  // Scan FSM next-state logic; stop overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dwell_nxt = r_dwell;
    w_mode_nxt  = r_mode;
    w_down_nxt  = r_down;
    w_sel_nxt   = r_sel;
    w_sd_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_ON;
          w_mode_nxt  = mode;
          w_dwell_nxt = w_dwell_eff;
          w_cnt_nxt   = w_dwell_eff;
          w_down_nxt  = 1'b0;
          w_sel_nxt   = (mode == 2'b01) ? 3'd7 : 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ON: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          if ((r_mode == 2'b10) && (r_sel == 3'd7)) begin
            w_state_nxt = S_IDLE;
            w_sd_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_BLANK;
            w_sel_nxt   = w_step_sel;
            w_down_nxt  = w_step_down;
            w_sd_nxt    = w_step_sd;
          end
        end else begin
          w_cnt_nxt = r_cnt - DWELL_ONE;
        end
      end
      S_BLANK: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = r_dwell;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered decoder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dwell      <= '0;
      r_mode       <= 2'b00;
      r_down       <= 1'b0;
      r_sel        <= 3'd0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dwell      <= w_dwell_nxt;
      r_mode       <= w_mode_nxt;
      r_down       <= w_down_nxt;
      r_sel        <= w_sel_nxt;
      r_en         <= (w_state_nxt == S_ON);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_sweep_done <= w_sd_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: directed scenarios plus random traffic against
// a model that derives outputs from elapsed time since the accepted start.
module tb_decoder_scan_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] dwell = '0;
  logic [2:0]    sel;
  logic          en, busy, sweep_done;

  decoder_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dwell(dwell),
    .sel(sel), .en(en), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sd_count = 0;

  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [1:0] m_mode = 2'b00;
  int         m_d = 1;
  logic [2:0] e_sel = 3'd0;
  bit         e_en = 1'b0, e_busy = 1'b0, e_sd = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel visited as the k-th channel of a scan in the given order.
  function automatic logic [2:0] chan(input logic [1:0] md, input int k);
    int p;
    p = k % 14;
    case (md)
      2'b00:   return 3'(k % 8);
      2'b01:   return 3'(7 - (k % 8));
      2'b10:   return (k > 7) ? 3'd7 : 3'(k);
      default: return (p <= 7) ? 3'(p) : 3'(14 - p);
    endcase
  endfunction

  // Whether leaving the k-th channel ends a sweep.
  function automatic bit done_after(input logic [1:0] md, input int k);
    int p;
    p = k % 14;
    case (md)
      2'b00:   return (k % 8) == 7;
      2'b01:   return (k % 8) == 7;
      2'b10:   return k == 7;
      default: return (p == 7) || (p == 0 && k > 0);
    endcase
  endfunction

  task automatic model_edge();
    int k, r;
    e_sd = 1'b0;
    if (!m_act) begin
      if (start && !stop) begin
        m_act = 1'b1; m_t = 0; m_mode = mode;
        m_d = (dwell == '0) ? 1 : int'(dwell);
      end
    end else if (stop) begin
      m_act = 1'b0;
    end else begin
      m_t++;
    end
    if (m_act) begin
      k = m_t / (m_d + 1);
      r = m_t % (m_d + 1);
      if (r < m_d) begin
        e_en = 1'b1; e_busy = 1'b1; e_sel = chan(m_mode, k);
      end else if (m_mode == 2'b10 && k == 7) begin
        e_en = 1'b0; e_busy = 1'b0; e_sel = 3'd7; e_sd = 1'b1; m_act = 1'b0;
      end else begin
        e_en = 1'b0; e_busy = 1'b1; e_sel = chan(m_mode, k + 1);
        e_sd = done_after(m_mode, k);
      end
    end else begin
      e_en = 1'b0; e_busy = 1'b0;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sel", int'(sel), int'(e_sel));
    chk("en", int'(en), int'(e_en));
    chk("busy", int'(busy), int'(e_busy));
    chk("sweep_done", int'(sweep_done), int'(e_sd));
    if (sweep_done) sd_count++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sd", int'(sweep_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_act = 1'b0; e_sel = 3'd0; e_en = 1'b0; e_busy = 1'b0; e_sd = 1'b0;
  endtask

  task automatic kick(input logic [1:0] md, input int dw);
    mode = md; dwell = DW'(dw); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit found;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("idle_busy", int'(busy), 0);

    // Mode 00, dwell 2: two sweeps in 48 cycles, then reset mid-scan at sel=5.
    kick(2'b00, 2);
    chk("m00_first_sel", int'(sel), 0);
    chk("m00_first_en", int'(en), 1);
    step(); step();
    chk("m00_blank_sel", int'(sel), 1);
    chk("m00_blank_en", int'(en), 0);
    sd_count = 0;
    for (int i = 0; i < 45; i++) step();
    chk("m00_sweeps", sd_count, 2);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (sel == 3'd5) && en;
    end
    chk("m00_reach_sel5", int'(found), 1);
    do_reset();
    for (int i = 0; i < 5; i++) step();

    // Mode 01, dwell 0 behaves as dwell 1.
    sd_count = 0;
    kick(2'b01, 0);
    chk("m01_first_sel", int'(sel), 7);
    step();
    chk("m01_blank_sel", int'(sel), 6);
    chk("m01_blank_en", int'(en), 0);
    for (int i = 0; i < 32; i++) step();
    chk("m01_sweeps", sd_count, 2);
    stop = 1'b1; step(); stop = 1'b0;

    // Mode 10, dwell 3: single sweep, start mid-sweep ignored.
    sd_count = 0;
    kick(2'b10, 3);
    for (int i = 0; i < 31; i++) begin
      start = (i == 10);
      mode = 2'b01;
      step();
    end
    start = 1'b0;
    chk("m10_end_busy", int'(busy), 0);
    chk("m10_end_en", int'(en), 0);
    chk("m10_end_sel", int'(sel), 7);
    chk("m10_end_sd", int'(sweep_done), 1);
    step();
    chk("m10_after_sd", int'(sweep_done), 0);
    chk("m10_sweeps", sd_count, 1);

    // Mode 11, dwell 1: turnaround pulses only.
    sd_count = 0;
    kick(2'b11, 1);
    for (int i = 0; i < 29; i++) step();
    chk("m11_sweeps", sd_count, 2);
    stop = 1'b1; step(); stop = 1'b0;

    // Stop while ON at channel 4.
    kick(2'b00, 3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = (sel == 3'd4) && en;
    end
    chk("stop_reach_sel4", int'(found), 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_en", int'(en), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_sel", int'(sel), 4);
    chk("stop_sd", int'(sweep_done), 0);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 8) == 0;
      stop  = ($urandom % 40) == 0;
      mode  = 2'($urandom % 4);
      dwell = DW'($urandom_range(0, 4));
      step();
    end
    start = 1'b0; stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
